// File: rtl/hpdcache_sram_ctrl_pkg.sv
// Shared types and constants for the hpdcache 1RW write-masked SRAM controller.
//   sram_ctrl_state_e : controller FSM state (INIT = clearing sweep, SERVE = arbitration)
//   WMASK_ONE         : one bit of the full write mask, replicated to the word width
package hpdcache_sram_ctrl_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    SERVE = 1'b1
  } sram_ctrl_state_e;

  localparam logic WMASK_ONE = 1'b1;

endpackage

// File: rtl/hpdcache_rrarb.sv
// NREQ-way round-robin arbiter with a one-hot grant.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   req_i         : request vector (already qualified by the caller)
//   ack_i         : grant is consumed this cycle; pointer advances past the winner
//   gnt_o         : one-hot grant (or zero when nothing requests)
//   gnt_idx_o     : binary index of the granted requester
module hpdcache_rrarb #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [NREQ-1:0] req_i,
  input  logic            ack_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   gnt_idx_o
);

  logic [PW-1:0] ptr;
  logic          found;
  int            idx;

  // Scan starting at the pointer, wrapping; first valid requester wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < int'(NREQ); i++) begin
      idx = (int'(ptr) + i) % int'(NREQ);
      if (!found && req_i[idx]) begin
        found       = 1'b1;
        gnt_o[idx]  = 1'b1;
        gnt_idx_o   = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr <= '0;
    end else if (ack_i && found) begin
      ptr <= (gnt_idx_o == PW'(NREQ - 1)) ? '0 : gnt_idx_o + 1'b1;
    end
  end

endmodule

// File: rtl/hpdcache_sram_wmask_1rw_ctrl.sv
// Sequencer and arbiter in front of one 1RW write-masked SRAM macro.
// After reset or a flush in SERVE, every row is cleared with a full-mask write sweep;
// afterwards NREQ requesters share the port round-robin.
// Handshake: a request transfers in the cycle where req_valid_i[i] && req_ready_o[i];
// ready is combinational from valid, so requesters hold valid and payload until ready.
// Read data returns one cycle after acceptance on rsp_valid_o[i] with no backpressure.
// Ports:
//   clk_i, rst_ni                : clock, asynchronous active-low reset
//   flush_i                      : re-clear the array (ignored while already clearing)
//   init_done_o                  : array cleared, requests are being served
//   req_valid/ready/we/addr/wdata/wmask : per-requester request channel (packed)
//   rsp_valid_o, rsp_rdata_o     : read response, shared data bus
//   sram_*                       : macro interface (rdata registered inside macro)
//   dbg_state_o                  : current FSM state
module hpdcache_sram_wmask_1rw_ctrl
  import hpdcache_sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = 3,
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned NDATA     = 1,
  parameter int unsigned DEPTH     = 2 ** ADDR_SIZE,
  parameter int unsigned NREQ      = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                flush_i,
  output logic                                init_done_o,
  input  logic [NREQ-1:0]                     req_valid_i,
  output logic [NREQ-1:0]                     req_ready_o,
  input  logic [NREQ-1:0]                     req_we_i,
  input  logic [NREQ*ADDR_SIZE-1:0]           req_addr_i,
  input  logic [NREQ*NDATA*DATA_SIZE-1:0]     req_wdata_i,
  input  logic [NREQ*NDATA*DATA_SIZE-1:0]     req_wmask_i,
  output logic [NREQ-1:0]                     rsp_valid_o,
  output logic [NDATA*DATA_SIZE-1:0]          rsp_rdata_o,
  output logic                                sram_cs_o,
  output logic                                sram_we_o,
  output logic [ADDR_SIZE-1:0]                sram_addr_o,
  output logic [NDATA*DATA_SIZE-1:0]          sram_wdata_o,
  output logic [NDATA*DATA_SIZE-1:0]          sram_wmask_o,
  input  logic [NDATA*DATA_SIZE-1:0]          sram_rdata_i,
  output sram_ctrl_state_e                    dbg_state_o
);

  localparam int unsigned DW = NDATA * DATA_SIZE;
  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // Sweep exit is a compare against the last row so DEPTH == 2**ADDR_SIZE needs no extra bit.
  localparam logic [ADDR_SIZE-1:0] LAST_ROW = ADDR_SIZE'(DEPTH - 1);

  sram_ctrl_state_e     state;
  logic [ADDR_SIZE-1:0] init_ptr;
  logic                 init_done;
  logic [NREQ-1:0]      rd_pending;
  logic                 serve_en;
  logic [NREQ-1:0]      arb_req;
  logic [NREQ-1:0]      gnt;
  logic [PW-1:0]        gnt_idx;

  // A flush cycle grants nothing so no request slips in ahead of the clear.
  assign serve_en = (state == SERVE) && !flush_i;
  assign arb_req  = req_valid_i & {NREQ{serve_en}};

  hpdcache_rrarb #(.NREQ(NREQ), .PW(PW)) i_rrarb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (arb_req),
    .ack_i     (serve_en),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  always_comb begin
    sram_cs_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_wmask_o = '0;
    if (state == INIT) begin
      sram_cs_o    = 1'b1;
      sram_we_o    = 1'b1;
      sram_addr_o  = init_ptr;
      sram_wmask_o = {DW{WMASK_ONE}};
    end else begin
      sram_cs_o = |gnt;
      for (int i = 0; i < int'(NREQ); i++) begin
        if (gnt[i]) begin
          sram_we_o    = req_we_i[i];
          sram_addr_o  = req_addr_i[i*ADDR_SIZE +: ADDR_SIZE];
          sram_wdata_o = req_wdata_i[i*DW +: DW];
          sram_wmask_o = req_wmask_i[i*DW +: DW];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= INIT;
      init_ptr   <= '0;
      init_done  <= 1'b0;
      rd_pending <= '0;
    end else begin
      // gnt is zero outside SERVE, so a read accepted just before a flush still
      // responds during the sweep and nothing new is recorded while clearing.
      rd_pending <= gnt & ~req_we_i;
      case (state)
        INIT: begin
          if (init_ptr == LAST_ROW) begin
            state     <= SERVE;
            init_done <= 1'b1;
          end else begin
            init_ptr <= init_ptr + 1'b1;
          end
        end
        SERVE: begin
          if (flush_i) begin
            state     <= INIT;
            init_ptr  <= '0;
            init_done <= 1'b0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  assign req_ready_o = gnt;
  assign rsp_valid_o = rd_pending;
  assign rsp_rdata_o = sram_rdata_i;
  assign init_done_o = init_done;
  assign dbg_state_o = state;

endmodule
